// File: rtl/gb_bus_pkg.sv
// Shared types and constants for the GB CPU bus bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gb_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] HRAM_BASE        = 16'hFF80;
  localparam logic [15:0] HRAM_LAST        = 16'hFFFE;
  localparam logic [7:0]  OPEN_BUS_DEFAULT = 8'hFF;

  // True when the address falls inside the high-RAM window.
  function automatic logic in_hram(input logic [15:0] addr);
    return (addr >= HRAM_BASE) && (addr <= HRAM_LAST);
  endfunction

endpackage

// File: rtl/gb_hram.sv
// 127x8 high RAM with synchronous read; contents are deliberately not reset.
// Latency: write lands on the clock edge, read data appears 1 cycle after re.
// Backpressure: none; always accepts.
module gb_hram (
  input  logic       clk,
  input  logic       we,
  input  logic       re,
  input  logic [6:0] idx,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem [0:126];

  // Single port: write and registered read share the index.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/gb_cpu_bus_bridge.sv
// CPU strobe to mem req/ack bridge with timeout; optional HRAM via GB_BUS_HRAM_EN.
// Latency: req 1 cycle after strobe; wait_n rises 1 cycle after ack (or after timeout).
// Backpressure: CPU stalled via cpu_wait_n until memory answers or TIMEOUT expires.
module gb_cpu_bus_bridge
  import gb_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [7:0]  OPEN_BUS = OPEN_BUS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_mreq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_di,
  output logic        cpu_wait_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        timeout
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state;
  logic [7:0] cnt;
  logic       wait_q;
  logic [7:0] di_q;
  logic       start;
  logic       wr_req;
  logic       hram_hit;

  // Both strobes low counts as a write.
  assign start  = ~cpu_mreq_n & (~cpu_rd_n | ~cpu_wr_n);
  assign wr_req = ~cpu_wr_n;

`ifdef GB_BUS_HRAM_EN
  logic       hram_we;
  logic       hram_re;
  logic       hram_sel_q;
  logic [7:0] hram_rdata;
  logic [15:0] hram_off;

  assign hram_hit = in_hram(cpu_addr);
  assign hram_off = cpu_addr - HRAM_BASE;
  assign hram_we  = reset_n & (state == IDLE) & start & hram_hit & wr_req;
  assign hram_re  = reset_n & (state == IDLE) & start & hram_hit & ~wr_req;

  gb_hram u_hram (
    .clk   (clk),
    .we    (hram_we),
    .re    (hram_re),
    .idx   (hram_off[6:0]),
    .wdata (cpu_dout),
    .rdata (hram_rdata)
  );

  // Marks the single DONE cycle where cpu_di must come straight from the RAM.
  always_ff @(posedge clk) begin
    if (!reset_n) hram_sel_q <= 1'b0;
    else          hram_sel_q <= hram_re;
  end

  assign cpu_di = hram_sel_q ? hram_rdata : di_q;
`else
  assign hram_hit = 1'b0;
  assign cpu_di   = di_q;
`endif

  // Stall in the strobe cycle itself; HRAM writes complete immediately so never stall.
  assign cpu_wait_n = wait_q & ~(reset_n & (state == IDLE) & start & ~(hram_hit & wr_req));

  // Transaction FSM: capture in IDLE, wait for ack or timeout in REQ, hold in DONE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      wait_q    <= 1'b1;
      di_q      <= OPEN_BUS_DEFAULT;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'd0;
      mem_wdata <= 8'd0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (hram_hit) begin
              state <= DONE;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= wr_req;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_dout;
              wait_q    <= 1'b0;
              cnt       <= 8'd0;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          cnt <= cnt + 8'd1;
          // An ack on the last allowed cycle still beats the timeout.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) di_q <= mem_rdata;
            wait_q  <= 1'b1;
            state   <= DONE;
          end else if (cnt == TIMEOUT_CNT) begin
            mem_req <= 1'b0;
            if (!mem_we) di_q <= OPEN_BUS;
            timeout <= 1'b1;
            wait_q  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
`ifdef GB_BUS_HRAM_EN
          // Fold the RAM output into the held data so cpu_di stays stable afterwards.
          if (hram_sel_q) di_q <= hram_rdata;
`endif
          if (cpu_mreq_n) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
